id_ex_hazard_stage: RTL and testbench

//   ID/EX boundary of the 5-stage RV32I pipeline. Detects load-use hazards and drives control_sel

---
 rtl/id_ex_hazard_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline boundary for a 5-stage RV32I core: load-use hazard detection, front-end stall
// control, and the ID/EX register with flush/hold/bubble handling plus saturating perf counters.
module id_ex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_memread,
    input  logic             id_memtoreg,
    input  logic             id_memwrite,
    input  logic             id_regwrite,
    input  logic             id_branch,
    input  logic             id_alusrc,
    input  logic [1:0]       id_aluop,
    input  logic             flush,
    input  logic             hold,
    output logic             control_sel,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             ex_memread,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_regwrite,
    output logic             ex_branch,
    output logic             ex_alusrc,
    output logic [1:0]       ex_aluop,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_BUBBLE,
        UPD_HOLD,
        UPD_FLUSH
    } upd_e;

    ctrl_t             ctrl_q, ctrl_d, id_ctrl;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              funct7b5_q, funct7b5_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic uses_rs1, uses_rs2, legal_op, hazard;
    upd_e upd;

    assign id_ctrl = '{memread:  id_memread,
                       memtoreg: id_memtoreg,
                       memwrite: id_memwrite,
                       regwrite: id_regwrite,
                       branch:   id_branch,
                       alusrc:   id_alusrc,
                       aluop:    id_aluop};

    // Hazard decode only looks at the instruction sitting in ID against the load in EX.
    always_comb begin
        uses_rs1 = (id_opcode == OP_R)     || (id_opcode == OP_IMM) ||
                   (id_opcode == OP_LOAD)  || (id_opcode == OP_STORE) ||
                   (id_opcode == OP_BRANCH);
        uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
        legal_op = uses_rs1;
        hazard   = ctrl_q.memread && (rd_q != 5'd0) &&
                   ((uses_rs1 && (id_rs1 == rd_q)) || (uses_rs2 && (id_rs2 == rd_q)));
    end

    assign control_sel = hazard & ~flush;
    assign pc_write    = ~(hazard | hold) | flush;
    assign if_id_write = ~(hazard | hold) | flush;

    always_comb begin
        if (flush)       upd = UPD_FLUSH;
        else if (hold)   upd = UPD_HOLD;
        else if (hazard) upd = UPD_BUBBLE;
        else             upd = UPD_LOAD;
    end

    // NOTE: every signal assigned in this block gets a default first, so no path leaves a latch.
    always_comb begin
        ctrl_d      = ctrl_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        funct7b5_d  = funct7b5_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        unique case (upd)
            UPD_FLUSH: begin
                ctrl_d     = '0;
                valid_d    = 1'b0;
                pc_d       = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
                rs1_d      = '0;
                rs2_d      = '0;
                rd_d       = '0;
                funct3_d   = '0;
                funct7b5_d = 1'b0;
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            end
            UPD_HOLD: begin
            end
            UPD_BUBBLE, UPD_LOAD: begin
                // A bubble still latches the ID datapath; only the control word and valid are zeroed.
                pc_d       = id_pc;
                rs1_data_d = id_rs1_data;
                rs2_data_d = id_rs2_data;
                imm_d      = id_imm;
                rs1_d      = id_rs1;
                rs2_d      = id_rs2;
                rd_d       = id_rd;
                funct3_d   = id_funct3;
                funct7b5_d = id_funct7b5;
                if (upd == UPD_BUBBLE) begin
                    ctrl_d  = '0;
                    valid_d = 1'b0;
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
                end else begin
                    ctrl_d  = legal_op ? id_ctrl : '0;
                    valid_d = legal_op;
                end
            end
            default: begin
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            funct7b5_q  <= funct7b5_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_memread  = ctrl_q.memread;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_branch   = ctrl_q.branch;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7b5 = funct7b5_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage: a driver pushes hand-computed expectations per cycle,
// a monitor checks combinational outputs mid-cycle and registered outputs just after the edge.
module tb_id_ex_hazard_stage;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [7:0]  id_ctrl;
    logic        flush, hold;

    logic        control_sel, pc_write, if_id_write;
    logic        ex_memread, ex_memtoreg, ex_memwrite, ex_regwrite, ex_branch, ex_alusrc;
    logic [1:0]  ex_aluop;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_control_sel, s_pc_write, s_if_id_write;
    logic        s_memread, s_memtoreg, s_memwrite, s_regwrite, s_branch, s_alusrc;
    logic [1:0]  s_aluop;
    logic        s_valid;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_funct3;
    logic        s_funct7b5;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_memread(id_ctrl[7]), .id_memtoreg(id_ctrl[6]), .id_memwrite(id_ctrl[5]),
        .id_regwrite(id_ctrl[4]), .id_branch(id_ctrl[3]), .id_alusrc(id_ctrl[2]),
        .id_aluop(id_ctrl[1:0]), .flush(flush), .hold(hold),
        .control_sel(control_sel), .pc_write(pc_write), .if_id_write(if_id_write),
        .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used to reach saturation quickly.
    id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_memread(id_ctrl[7]), .id_memtoreg(id_ctrl[6]), .id_memwrite(id_ctrl[5]),
        .id_regwrite(id_ctrl[4]), .id_branch(id_ctrl[3]), .id_alusrc(id_ctrl[2]),
        .id_aluop(id_ctrl[1:0]), .flush(flush), .hold(hold),
        .control_sel(s_control_sel), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .ex_memread(s_memread), .ex_memtoreg(s_memtoreg), .ex_memwrite(s_memwrite),
        .ex_regwrite(s_regwrite), .ex_branch(s_branch), .ex_alusrc(s_alusrc),
        .ex_aluop(s_aluop), .ex_valid(s_valid), .ex_pc(s_pc),
        .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3),
        .ex_funct7b5(s_funct7b5), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        string       name;
        logic        csel;
        logic        pcw;
        logic        valid;
        logic [7:0]  ctrl;
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [15:0] stall;
        logic [15:0] flsh;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [7:0] C_LW   = 8'hD4;
    localparam logic [7:0] C_ADD  = 8'h12;
    localparam logic [7:0] C_ADDI = 8'h16;
    localparam logic [7:0] C_SW   = 8'h24;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input string name, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl,
                        input logic [31:0] pc, input logic fl, input logic hd,
                        input logic e_csel, input logic e_pcw, input logic e_valid,
                        input logic [7:0] e_ctrl, input logic e_chk, input logic [4:0] e_rd,
                        input logic [31:0] e_pc, input logic [15:0] e_stall,
                        input logic [15:0] e_flush);
        exp_t e;
        @(posedge clk);
        #2;
        id_opcode   = op;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_ctrl     = ctrl;
        id_pc       = pc;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h5A5A_0000;
        id_imm      = pc + 32'd1;
        id_funct3   = pc[2:0];
        id_funct7b5 = pc[3];
        flush       = fl;
        hold        = hd;
        e = '{name: name, csel: e_csel, pcw: e_pcw, valid: e_valid, ctrl: e_ctrl,
              chk_data: e_chk, rd: e_rd, pc: e_pc, stall: e_stall, flsh: e_flush};
        exp_q.push_back(e);
    endtask

    // Monitor: combinational outputs are checked mid-cycle, registered ones 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check({e.name, ".control_sel"}, control_sel, e.csel);
                check({e.name, ".pc_write"}, {pc_write, if_id_write}, {e.pcw, e.pcw});
                @(posedge clk);
                #1;
                check({e.name, ".ex_valid"}, ex_valid, e.valid);
                check({e.name, ".ex_ctrl"},
                      {ex_memread, ex_memtoreg, ex_memwrite, ex_regwrite, ex_branch,
                       ex_alusrc, ex_aluop}, e.ctrl);
                if (e.chk_data) begin
                    check({e.name, ".ex_rd"}, ex_rd, e.rd);
                    check({e.name, ".ex_pc"}, ex_pc, e.pc);
                end
                check({e.name, ".stall_cnt"}, stall_cnt, e.stall);
                check({e.name, ".flush_cnt"}, flush_cnt, e.flsh);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drain();
        int budget;
        budget = 100;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("drain_timeout", exp_q.size(), 0);
        #3;
    endtask

    initial begin
        rst_n = 1'b0;
        id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_ctrl = '0;
        id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_funct3 = '0; id_funct7b5 = 1'b0; flush = 1'b0; hold = 1'b0;
        #12;
        check("rst.control_sel", control_sel, 1'b0);
        check("rst.pc_write", {pc_write, if_id_write}, 2'b11);
        check("rst.ex_valid", ex_valid, 1'b0);
        check("rst.counters", {stall_cnt, flush_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //    name      op     rs1 rs2 rd  ctrl    pc      fl hd  csel pcw val e_ctrl  chk rd  e_pc  stl fls
        step("lw1",     7'h03, 1,  0,  5,  C_LW,   'h100,  0, 0,  0,   1,  1,  C_LW,   1,  5,  'h100, 0, 0);
        step("add_haz", 7'h33, 5,  2,  6,  C_ADD,  'h104,  0, 0,  1,   0,  0,  8'h00,  0,  0,  0,     1, 0);
        step("add_go",  7'h33, 5,  2,  6,  C_ADD,  'h104,  0, 0,  0,   1,  1,  C_ADD,  1,  6,  'h104, 1, 0);
        step("lw_x0",   7'h03, 1,  0,  0,  C_LW,   'h108,  0, 0,  0,   1,  1,  C_LW,   1,  0,  'h108, 1, 0);
        step("add_x0",  7'h33, 0,  2,  6,  C_ADD,  'h10C,  0, 0,  0,   1,  1,  C_ADD,  1,  6,  'h10C, 1, 0);
        step("lw2",     7'h03, 1,  0,  5,  C_LW,   'h110,  0, 0,  0,   1,  1,  C_LW,   1,  5,  'h110, 1, 0);
        step("addi_hz", 7'h13, 5,  1,  7,  C_ADDI, 'h114,  0, 0,  1,   0,  0,  8'h00,  0,  0,  0,     2, 0);
        step("addi_go", 7'h13, 5,  1,  7,  C_ADDI, 'h114,  0, 0,  0,   1,  1,  C_ADDI, 1,  7,  'h114, 2, 0);
        step("lw3",     7'h03, 1,  0,  5,  C_LW,   'h118,  0, 0,  0,   1,  1,  C_LW,   1,  5,  'h118, 2, 0);
        step("addi_r2", 7'h13, 6,  5,  7,  C_ADDI, 'h11C,  0, 0,  0,   1,  1,  C_ADDI, 1,  7,  'h11C, 2, 0);
        step("lw4",     7'h03, 1,  0,  5,  C_LW,   'h120,  0, 0,  0,   1,  1,  C_LW,   1,  5,  'h120, 2, 0);
        step("flush_hz",7'h33, 5,  2,  6,  C_ADD,  'h124,  1, 0,  0,   1,  0,  8'h00,  1,  0,  0,     2, 1);
        step("post_fl", 7'h33, 5,  2,  6,  C_ADD,  'h124,  0, 0,  0,   1,  1,  C_ADD,  1,  6,  'h124, 2, 1);
        for (int i = 0; i < 3; i++)
            step("hold",    7'h33, 1,  2,  8,  C_ADD,  'h128,  0, 1,  0,   0,  1,  C_ADD,  1,  6,  'h124, 2, 1);
        step("hold_rel",7'h33, 1,  2,  8,  C_ADD,  'h128,  0, 0,  0,   1,  1,  C_ADD,  1,  8,  'h128, 2, 1);
        step("illegal", 7'h7F, 1,  2,  9,  8'hFF,  'h12C,  0, 0,  0,   1,  0,  8'h00,  1,  9,  'h12C, 2, 1);
        step("nop",     7'h00, 0,  0,  0,  8'h00,  'h000,  0, 0,  0,   1,  0,  8'h00,  1,  0,  0,     2, 1);
        step("lw5",     7'h03, 1,  0,  5,  C_LW,   'h130,  0, 0,  0,   1,  1,  C_LW,   1,  5,  'h130, 2, 1);
        step("sw_haz",  7'h23, 1,  5,  0,  C_SW,   'h134,  0, 0,  1,   0,  0,  8'h00,  0,  0,  0,     3, 1);
        step("sw_go",   7'h23, 1,  5,  0,  C_SW,   'h134,  0, 0,  0,   1,  1,  C_SW,   1,  0,  'h134, 3, 1);
        step("lw6",     7'h03, 1,  0,  5,  C_LW,   'h138,  0, 0,  0,   1,  1,  C_LW,   1,  5,  'h138, 3, 1);
        step("hold_hz", 7'h33, 5,  2,  6,  C_ADD,  'h13C,  0, 1,  1,   0,  1,  C_LW,   1,  5,  'h138, 3, 1);
        step("haz_rel", 7'h33, 5,  2,  6,  C_ADD,  'h13C,  0, 0,  1,   0,  0,  8'h00,  0,  0,  0,     4, 1);
        step("add_go2", 7'h33, 5,  2,  6,  C_ADD,  'h13C,  0, 0,  0,   1,  1,  C_ADD,  1,  6,  'h13C, 4, 1);
        for (int i = 0; i < 4; i++) begin
            step("sat_lw",  7'h03, 1, 0, 5, C_LW,  32'h200 + 16*i, 0, 0, 0, 1, 1, C_LW, 1, 5,
                 32'h200 + 16*i, 16'(4 + i), 1);
            step("sat_haz", 7'h33, 5, 2, 6, C_ADD, 32'h204 + 16*i, 0, 0, 1, 0, 0, 8'h00, 0, 0,
                 0, 16'(5 + i), 1);
            step("sat_go",  7'h33, 5, 2, 6, C_ADD, 32'h204 + 16*i, 0, 0, 0, 1, 1, C_ADD, 1, 6,
                 32'h204 + 16*i, 16'(5 + i), 1);
        end
        drain();
        check("sat.stall_cnt_narrow", s_stall_cnt, 3'd7);
        check("sat.flush_cnt_narrow", s_flush_cnt, 3'd1);

        // Async reset while a load-use stall is being requested.
        @(posedge clk);
        #2;
        id_opcode = 7'h03; id_rs1 = 1; id_rs2 = 0; id_rd = 5; id_ctrl = C_LW; id_pc = 'h300;
        @(posedge clk);
        #2;
        id_opcode = 7'h33; id_rs1 = 5; id_rs2 = 2; id_rd = 6; id_ctrl = C_ADD; id_pc = 'h304;
        #1;
        check("arst.pre_control_sel", control_sel, 1'b1);
        check("arst.pre_pc_write", pc_write, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst.ex_valid", ex_valid, 1'b0);
        check("arst.ex_ctrl", {ex_memread, ex_memtoreg, ex_regwrite, ex_alusrc}, 4'd0);
        check("arst.ex_fields", {ex_rd, ex_pc}, 37'd0);
        check("arst.counters", {stall_cnt, flush_cnt}, 32'd0);
        check("arst.stall_ctl", {control_sel, pc_write, if_id_write}, 3'b011);
        #20;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
